vga_timing_gen: RTL and testbench

- Generates VGA raster timing, default 640x480 at 60 Hz, on the 25 MHz pixel clock produced by the clock divider.
- Drives the HSYNC/VSYNC monitor pins.
- Gives the downstream pixel/framebuffer logic the current pixel coordinates, an active-video qualifier and frame/line strobes.

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_axis_counter.sv | 49 ++++
 rtl/vga_timing_gen.sv | 89 ++++++++
 tb/tb_vga_timing_gen.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, phase encoding and phase decode helper.
// Default 640x480@60 numbers; totals derived from the four segments.
package vga_pkg;

    localparam int unsigned DEF_CNT_W    = 10;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;

    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam int unsigned H_TOTAL =
        DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned V_TOTAL =
        DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef enum logic [1:0] {
        ACT   = 2'd0,
        FRONT = 2'd1,
        SYN   = 2'd2,
        BACK  = 2'd3
    } phase_t;

    // Phase of a position on one axis. A zero-length segment has an
    // empty range, so it is skipped naturally.
    function automatic phase_t phase_of(
        input int unsigned pos,
        input int unsigned act,
        input int unsigned fp,
        input int unsigned sync
    );
        if (pos < act)
            return ACT;
        if (pos < act + fp)
            return FRONT;
        if (pos < act + fp + sync)
            return SYN;
        return BACK;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus phase state register.
// Ports: CLK, RST (sync high), EN; cnt, wrap (last count and EN), phase_nxt.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned FP     = DEF_H_FP,
    parameter int unsigned SYNC   = DEF_H_SYNC,
    parameter int unsigned BP     = DEF_H_BP,
    parameter int unsigned W      = DEF_CNT_W
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output phase_t       phase_nxt
);

    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    localparam phase_t PH_ZERO = phase_of(0, ACTIVE, FP, SYNC);

    logic [W-1:0] cnt_nxt;
    phase_t       phase_q;

    // The phase changes only when the next count lands on a segment
    // boundary; decoding the next count keeps it aligned with cnt.
    always_comb begin
        wrap      = EN && (cnt == LAST);
        cnt_nxt   = cnt;
        phase_nxt = phase_q;
        if (EN) begin
            cnt_nxt   = wrap ? '0 : cnt + W'(1);
            phase_nxt = phase_of(32'(cnt_nxt), ACTIVE, FP, SYNC);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt     <= '0;
            phase_q <= PH_ZERO;
        end else begin
            cnt     <= cnt_nxt;
            phase_q <= phase_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: sync pins, pixel coordinates, video qualifier, strobes.
// Ports: CLK, RST, EN in; HSYNC, VSYNC, VIDEO_ON, PIX_X, PIX_Y, LINE_START, FRAME_START out.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter logic        SYNC_POL = 1'b0,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             VIDEO_ON,
    output logic [CNT_W-1:0] PIX_X,
    output logic [CNT_W-1:0] PIX_Y,
    output logic             LINE_START,
    output logic             FRAME_START
);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    phase_t           h_ph_nxt;
    phase_t           v_ph_nxt;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (CNT_W)
    ) u_h (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .cnt       (h_cnt),
        .wrap      (h_wrap),
        .phase_nxt (h_ph_nxt)
    );

    // The vertical axis advances once per line, on the horizontal wrap.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (CNT_W)
    ) u_v (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (h_wrap),
        .cnt       (v_cnt),
        .wrap      (v_wrap),
        .phase_nxt (v_ph_nxt)
    );

    assign PIX_X = h_cnt;
    assign PIX_Y = v_cnt;

    // Registered from next-state decode so every output refers to the
    // same (PIX_X, PIX_Y) as the counters. A wrap means the next
    // position is x=0 (line) or (0,0) (frame).
    always_ff @(posedge CLK) begin
        if (RST) begin
            HSYNC       <= ~SYNC_POL;
            VSYNC       <= ~SYNC_POL;
            VIDEO_ON    <= 1'b1;
            LINE_START  <= 1'b1;
            FRAME_START <= 1'b1;
        end else if (EN) begin
            HSYNC       <= (h_ph_nxt == SYN) ? SYNC_POL : ~SYNC_POL;
            VSYNC       <= (v_ph_nxt == SYN) ? SYNC_POL : ~SYNC_POL;
            VIDEO_ON    <= (h_ph_nxt == ACT) && (v_ph_nxt == ACT);
            LINE_START  <= h_wrap;
            FRAME_START <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default, short-frame and tiny instances.
// Stimulus pushes expected outputs per edge; a negedge monitor pops and compares.
module tb_vga_timing_gen;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic EN  = 1'b0;

    always #5 CLK = ~CLK;

    logic [9:0] px [3];
    logic [9:0] py [3];
    logic       hs [3];
    logic       vs [3];
    logic       vo [3];
    logic       ls [3];
    logic       fs [3];

    vga_timing_gen u_a (
        .CLK(CLK), .RST(RST), .EN(EN),
        .HSYNC(hs[0]), .VSYNC(vs[0]), .VIDEO_ON(vo[0]),
        .PIX_X(px[0]), .PIX_Y(py[0]),
        .LINE_START(ls[0]), .FRAME_START(fs[0])
    );

    vga_timing_gen #(
        .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_b (
        .CLK(CLK), .RST(RST), .EN(EN),
        .HSYNC(hs[1]), .VSYNC(vs[1]), .VIDEO_ON(vo[1]),
        .PIX_X(px[1]), .PIX_Y(py[1]),
        .LINE_START(ls[1]), .FRAME_START(fs[1])
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(0), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_c (
        .CLK(CLK), .RST(RST), .EN(EN),
        .HSYNC(hs[2]), .VSYNC(vs[2]), .VIDEO_ON(vo[2]),
        .PIX_X(px[2]), .PIX_Y(py[2]),
        .LINE_START(ls[2]), .FRAME_START(fs[2])
    );

    int sel = 0;
    int m_x, m_y, m_hs, m_vs, m_vo, m_ls, m_fs;

    always_comb begin
        m_x  = int'(px[sel]);
        m_y  = int'(py[sel]);
        m_hs = int'(hs[sel]);
        m_vs = int'(vs[sel]);
        m_vo = int'(vo[sel]);
        m_ls = int'(ls[sel]);
        m_fs = int'(fs[sel]);
    end

    typedef struct {
        int x;
        int y;
        int hs;
        int vs;
        int vo;
        int ls;
        int fs;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    always @(negedge CLK) begin
        while (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("pix_x", m_x, mon_e.x);
            chk("pix_y", m_y, mon_e.y);
            chk("hsync", m_hs, mon_e.hs);
            chk("vsync", m_vs, mon_e.vs);
            chk("video_on", m_vo, mon_e.vo);
            chk("line_start", m_ls, mon_e.ls);
            chk("frame_start", m_fs, mon_e.fs);
        end
    end

    int ha, hf, hsw, hb, va, vf, vsw, vb;
    int mx = 0;
    int my = 0;
    int cyc = 0;

    int n_vo, n_hs, n_vs, hx_min, hx_max, vy_min, vy_max, y_max;
    int last_ls, last_fs, ls_per, fs_per;

    task automatic set_p(input int a, input int b, input int c, input int d,
                         input int e, input int f, input int g, input int h);
        ha = a; hf = b; hsw = c; hb = d;
        va = e; vf = f; vsw = g; vb = h;
    endtask

    task automatic clr_stats();
        n_vo = 0; n_hs = 0; n_vs = 0;
        hx_min = 9999; hx_max = -1;
        vy_min = 9999; vy_max = -1;
        y_max = -1;
        ls_per = 0; fs_per = 0;
    endtask

    task automatic clr_per();
        last_ls = -1;
        last_fs = -1;
    endtask

    task automatic step(input logic r, input logic e);
        exp_t ex;
        int ht, vt;
        RST = r;
        EN  = e;
        @(posedge CLK);
        cyc++;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        if (r) begin
            mx = 0;
            my = 0;
        end else if (e) begin
            if (mx == ht - 1) begin
                mx = 0;
                my = (my == vt - 1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        ex.x  = mx;
        ex.y  = my;
        ex.hs = (mx >= ha + hf && mx < ha + hf + hsw) ? 0 : 1;
        ex.vs = (my >= va + vf && my < va + vf + vsw) ? 0 : 1;
        ex.vo = (mx < ha && my < va) ? 1 : 0;
        ex.ls = (mx == 0) ? 1 : 0;
        ex.fs = (mx == 0 && my == 0) ? 1 : 0;
        q.push_back(ex);
        #1;
        if (m_vo == 1) n_vo++;
        if (m_hs == 0) begin
            n_hs++;
            if (m_x < hx_min) hx_min = m_x;
            if (m_x > hx_max) hx_max = m_x;
        end
        if (m_vs == 0) begin
            n_vs++;
            if (m_y < vy_min) vy_min = m_y;
            if (m_y > vy_max) vy_max = m_y;
        end
        if (m_y > y_max) y_max = m_y;
        if (m_ls == 1) begin
            if (last_ls >= 0) ls_per = cyc - last_ls;
            last_ls = cyc;
        end
        if (m_fs == 1) begin
            if (last_fs >= 0) fs_per = cyc - last_fs;
            last_fs = cyc;
        end
    endtask

    initial begin
        set_p(640, 16, 96, 48, 480, 10, 2, 33);
        sel = 0;
        clr_per();
        clr_stats();

        step(1, 1);
        step(1, 1);
        step(1, 1);
        chk("rst_x", m_x, 0);
        chk("rst_y", m_y, 0);
        chk("rst_hs", m_hs, 1);
        chk("rst_vs", m_vs, 1);
        chk("rst_vo", m_vo, 1);
        chk("rst_fs", m_fs, 1);

        step(0, 1);
        chk("first_x", m_x, 1);
        chk("first_fs", m_fs, 0);

        repeat (799) step(0, 1);
        clr_stats();
        repeat (800) step(0, 1);
        chk("line_vo_cnt", n_vo, 640);
        chk("line_hs_cnt", n_hs, 96);
        chk("line_hs_first", hx_min, 656);
        chk("line_hs_last", hx_max, 751);
        chk("line_period", ls_per, 800);

        repeat (655) step(0, 1);
        chk("pre_hold_x", m_x, 655);
        repeat (5) begin
            step(0, 0);
            chk("hold_x", m_x, 655);
            chk("hold_hs", m_hs, 1);
        end
        step(0, 1);
        chk("resume_x", m_x, 656);
        chk("resume_hs", m_hs, 0);

        set_p(640, 16, 96, 48, 20, 2, 2, 3);
        sel = 1;
        clr_per();
        step(1, 1);
        clr_stats();
        repeat (21600) step(0, 1);
        chk("frame_vs_cnt", n_vs, 1600);
        chk("frame_vs_first", vy_min, 22);
        chk("frame_vs_last", vy_max, 23);
        chk("frame_y_max", y_max, 26);
        chk("frame_period", fs_per, 21600);
        chk("frame_wrap_x", m_x, 0);
        chk("frame_wrap_y", m_y, 0);

        repeat (23 * 800 + 700) step(0, 1);
        chk("mid_x", m_x, 700);
        chk("mid_hs", m_hs, 0);
        chk("mid_vs", m_vs, 0);
        step(1, 0);
        chk("mrst_x", m_x, 0);
        chk("mrst_y", m_y, 0);
        chk("mrst_hs", m_hs, 1);
        chk("mrst_vs", m_vs, 1);
        chk("mrst_fs", m_fs, 1);
        step(0, 1);
        chk("mrst_next_x", m_x, 1);
        chk("mrst_next_y", m_y, 0);

        set_p(8, 0, 2, 2, 4, 1, 1, 1);
        sel = 2;
        clr_per();
        step(1, 1);
        clr_stats();
        repeat (168) step(0, 1);
        chk("small_line_period", ls_per, 12);
        chk("small_frame_period", fs_per, 84);
        chk("small_hs_cnt", n_hs, 28);
        chk("small_hs_first", hx_min, 8);
        chk("small_hs_last", hx_max, 9);
        chk("small_vs_cnt", n_vs, 24);
        chk("small_vs_line", vy_min, 5);
        chk("small_vo_cnt", n_vo, 64);

        @(negedge CLK);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
